// File: rtl/irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// irq_controller_pkg
// Shared definitions for the interrupt controller:
//   - IRQ_BASE          default byte base of the MMIO window
//   - IRQ_*_OFS         register offsets inside the window (8-byte stride)
//   - IRQ_WINDOW_SIZE   size of the decoded window in bytes
// -----------------------------------------------------------------------------
package irq_controller_pkg;

    localparam logic [63:0] IRQ_BASE        = 64'h3000;

    localparam logic [63:0] IRQ_PENDING_OFS = 64'h00;
    localparam logic [63:0] IRQ_ENABLE_OFS  = 64'h08;
    localparam logic [63:0] IRQ_ACTIVE_OFS  = 64'h10;

    // Three 8-byte registers; offsets beyond the last one are outside.
    localparam logic [63:0] IRQ_WINDOW_SIZE = 64'h18;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder, lowest set index wins. Purely combinational.
// Ports:
//   req    in   N      request bits
//   valid  out  1      at least one request bit set
//   index  out  IDX_W  index of the lowest set request bit (0 when !valid)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                valid = 1'b1;
                index = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Edge-triggered, fixed-priority interrupt controller with an MMIO register
// window (PENDING / ENABLE / ACTIVE) and a vector/ack handshake to the CPU.
// Ports:
//   clk               single clock
//   reset_n           asynchronous active-low reset
//   irq_src           source lines (synchronous to clk), interrupt = 0->1 edge
//   interrupt_vector  0 = none, k+1 = source k being signalled
//   interrupt_ack     CPU acknowledge of the current vector
//   bus_address       byte address
//   bus_write_data    write data, bits [NUM_SRC-1:0] used
//   bus_write_enable  write strobe
//   bus_read_enable   read strobe
//   bus_read_data     registered read data
//   bus_hit           address lies inside this block's window (combinational)
// -----------------------------------------------------------------------------
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter int          VEC_W     = 4,
    parameter logic [63:0] BASE_ADDR = IRQ_BASE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [VEC_W-1:0]   interrupt_vector,
    input  logic               interrupt_ack,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data,
    output logic               bus_hit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t             state_reg;
    logic [NUM_SRC-1:0] src_q_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC-1:0] ready;
    logic [63:0]        ofs;
    logic [63:0]        rd_mux;
    logic               wr_hit;
    logic               rd_hit;
    logic               cand_valid;
    logic [VEC_W-1:0]   cand_idx;
    logic               unused_wdata;

    // ---------------- address decode ----------------
    assign ofs     = bus_address - BASE_ADDR;
    assign bus_hit = (bus_address >= BASE_ADDR) && (ofs < IRQ_WINDOW_SIZE);
    assign wr_hit  = bus_write_enable && bus_hit;
    assign rd_hit  = bus_read_enable && bus_hit;

    assign unused_wdata = ^bus_write_data[63:NUM_SRC];

    // ---------------- pending bookkeeping ----------------
    assign rise    = irq_src & ~src_q_reg;
    assign w1c_clr = (wr_hit && ofs == IRQ_PENDING_OFS) ? bus_write_data[NUM_SRC-1:0] : '0;

    // The ack clears only the source whose vector is currently presented,
    // even if that source has since been masked.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ack_clr
            assign ack_clr[gi] = (state_reg == ST_ASSERT) && interrupt_ack &&
                                 (interrupt_vector == VEC_W'(gi + 1));
        end
    endgenerate

    // A new edge overrides any clear in the same cycle so no edge is lost.
    assign pending_next = (pending_reg & ~(ack_clr | w1c_clr)) | rise;
    assign ready        = pending_reg & enable_reg;

    irq_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (VEC_W)
    ) u_prio_enc (
        .req   (ready),
        .valid (cand_valid),
        .index (cand_idx)
    );

    // ---------------- read mux ----------------
    always_comb begin
        rd_mux = '0;
        if (ofs == IRQ_PENDING_OFS) begin
            rd_mux = 64'(pending_reg);
        end else if (ofs == IRQ_ENABLE_OFS) begin
            rd_mux = 64'(enable_reg);
        end else if (ofs == IRQ_ACTIVE_OFS) begin
            rd_mux = 64'(interrupt_vector);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q_reg     <= '0;
            pending_reg   <= '0;
            enable_reg    <= '0;
            bus_read_data <= '0;
        end else begin
            src_q_reg   <= irq_src;
            pending_reg <= pending_next;
            if (wr_hit && ofs == IRQ_ENABLE_OFS) begin
                enable_reg <= bus_write_data[NUM_SRC-1:0];
            end
            if (rd_hit) begin
                bus_read_data <= rd_mux;
            end
        end
    end

    // ---------------- handshake FSM ----------------
    // The vector is latched on entry to ASSERT and held there, so a later
    // higher-priority edge or a mask change cannot disturb the CPU's view.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            interrupt_vector <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cand_valid) begin
                        interrupt_vector <= cand_idx + VEC_W'(1);
                        state_reg        <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (interrupt_ack) begin
                        interrupt_vector <= '0;
                        state_reg        <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    interrupt_vector <= '0;
                    state_reg        <= ST_IDLE;
                end
                default: begin
                    interrupt_vector <= '0;
                    state_reg        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Self-checking bench for irq_controller: a table of register-access vectors
// followed by hand-written handshake sequences.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    localparam int          NUM_SRC = 4;
    localparam int          VEC_W   = 4;
    localparam logic [63:0] BASE    = 64'h3000;
    localparam logic [63:0] A_PEND  = BASE + 64'h00;
    localparam logic [63:0] A_EN    = BASE + 64'h08;
    localparam logic [63:0] A_ACT   = BASE + 64'h10;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_SRC-1:0] irq_src = '0;
    logic [VEC_W-1:0]   interrupt_vector;
    logic               interrupt_ack = 1'b0;
    logic [63:0]        bus_address = '0;
    logic [63:0]        bus_write_data = '0;
    logic               bus_write_enable = 1'b0;
    logic               bus_read_enable = 1'b0;
    logic [63:0]        bus_read_data;
    logic               bus_hit;

    int checks = 0;
    int errors = 0;

    irq_controller #(
        .NUM_SRC   (NUM_SRC),
        .VEC_W     (VEC_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .irq_src          (irq_src),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .bus_hit          (bus_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_write;
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic [63:0] raddr;
        logic [63:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [63:0] addr, input logic [63:0] data);
        bus_address      = addr;
        bus_write_data   = data;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] data);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
        data            = bus_read_data;
    endtask

    task automatic wait_vector(input string name, input logic [VEC_W-1:0] exp, input int max_cycles);
        int n = 0;
        while (interrupt_vector !== exp && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 64'(interrupt_vector), 64'(exp));
    endtask

    // Ack the presented vector; the vector must drop on that very edge.
    task automatic do_ack(input string name);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        check(name, 64'(interrupt_vector), 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic        seen;

        // register-access vectors, applied with no interrupt activity
        vecs[0] = '{1'b1, A_EN,         64'h5,  A_EN,         64'h5, 1'b1};
        vecs[1] = '{1'b1, A_EN,         '1,     A_EN,         64'hF, 1'b1};
        vecs[2] = '{1'b1, A_EN,         64'hA,  A_EN,         64'hA, 1'b1};
        vecs[3] = '{1'b0, 64'h0,        64'h0,  BASE + 64'h18, 64'hA, 1'b0};
        vecs[4] = '{1'b0, 64'h0,        64'h0,  BASE + 64'h4, 64'h0, 1'b1};
        vecs[5] = '{1'b1, BASE + 64'h4, 64'hF,  A_EN,         64'hA, 1'b1};
        vecs[6] = '{1'b1, BASE - 64'h8, 64'h3,  A_EN,         64'hA, 1'b1};
        vecs[7] = '{1'b1, A_EN,         64'h0,  A_ACT,        64'h0, 1'b1};

        // ---------------- reset ----------------
        #2;
        check("reset_vector", 64'(interrupt_vector), 64'd0);
        check("reset_rdata", bus_read_data, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bus_read(A_PEND, rd);
        check("reset_pending", rd, 64'h0);
        bus_read(A_EN, rd);
        check("reset_enable", rd, 64'h0);

        // ---------------- table ----------------
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_write) bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_address = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_hit", i), 64'(bus_hit), 64'(vecs[i].exp_hit));
            bus_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // ---------------- 1: single source ----------------
        bus_write(A_EN, 64'h1);
        irq_src[0] = 1'b1;
        wait_vector("t1_vector", 4'd1, 2);
        bus_read(A_ACT, rd);
        check("t1_active", rd, 64'h1);
        do_ack("t1_ack_drop");
        tick();
        check("t1_gap", 64'(interrupt_vector), 64'd0);
        bus_read(A_PEND, rd);
        check("t1_pending", rd, 64'h0);

        // ---------------- 5: level held, no retrigger ----------------
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (interrupt_vector != '0) seen = 1'b1;
        end
        check("t5_no_retrigger", 64'(seen), 64'd0);
        bus_read(A_PEND, rd);
        check("t5_pending", rd, 64'h0);
        irq_src = '0;
        tick();

        // ---------------- 2: simultaneous edges ----------------
        bus_write(A_EN, 64'hF);
        irq_src = 4'b0110;
        wait_vector("t2_vector_a", 4'd2, 4);
        do_ack("t2_ack_a");
        tick();
        check("t2_gap", 64'(interrupt_vector), 64'd0);
        wait_vector("t2_vector_b", 4'd3, 3);
        do_ack("t2_ack_b");
        tick();
        tick();
        bus_read(A_PEND, rd);
        check("t2_pending", rd, 64'h0);
        check("t2_idle", 64'(interrupt_vector), 64'd0);
        irq_src = '0;

        // ---------------- 3: masked source ----------------
        bus_write(A_EN, 64'h0);
        irq_src[3] = 1'b1;
        tick();
        tick();
        bus_read(A_PEND, rd);
        check("t3_pending", rd, 64'h8);
        check("t3_masked_vector", 64'(interrupt_vector), 64'd0);
        bus_write(A_PEND, 64'h7);
        bus_read(A_PEND, rd);
        check("t3_w1c_other_bits", rd, 64'h8);
        bus_write(A_EN, 64'h8);
        wait_vector("t3_vector", 4'd4, 3);
        do_ack("t3_ack");
        bus_read(A_PEND, rd);
        check("t3_pending_after", rd, 64'h0);
        irq_src = '0;
        tick();

        // ---------------- W1C clears a pending bit ----------------
        bus_write(A_EN, 64'h0);
        irq_src[2] = 1'b1;
        tick();
        tick();
        bus_write(A_PEND, 64'h4);
        bus_read(A_PEND, rd);
        check("w1c_clear", rd, 64'h0);
        irq_src = '0;
        tick();

        // ---------------- 4: set beats clear ----------------
        bus_write(A_EN, 64'h1);
        irq_src[0] = 1'b1;
        wait_vector("t4_vector", 4'd1, 3);
        irq_src[0] = 1'b0;
        tick();
        // ack, W1C of bit 0 and a fresh edge on src0 all on one edge
        bus_address      = A_PEND;
        bus_write_data   = 64'h1;
        bus_write_enable = 1'b1;
        irq_src[0]       = 1'b1;
        do_ack("t4_ack");
        bus_write_enable = 1'b0;
        bus_read(A_PEND, rd);
        check("t4_set_wins", rd, 64'h1);
        wait_vector("t4_second_vector", 4'd1, 3);

        // ---------------- 6: reset mid-handshake ----------------
        irq_src = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_vector", 64'(interrupt_vector), 64'd0);
        check("t6_async_rdata", bus_read_data, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        bus_read(A_ACT, rd);
        check("t6_active", rd, 64'h0);
        bus_read(A_EN, rd);
        check("t6_enable", rd, 64'h0);
        bus_read(A_PEND, rd);
        check("t6_pending", rd, 64'h0);
        tick();
        check("t6_idle", 64'(interrupt_vector), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
